// File: rtl/xsleena_cen_pkg.sv
// -----------------------------------------------------------------------------
// xsleena_cen_pkg
// Shared constants for the 48 MHz clock-enable tree: the core clock rate,
// named divisors for the common derived rates, channel index names, and a
// helper that packs two per-channel byte values into a DIV/PHASE list.
// -----------------------------------------------------------------------------
package xsleena_cen_pkg;

    localparam int unsigned CEN_CLK_HZ = 48_000_000;

    // Divisors from the 48 MHz core clock
    localparam int unsigned DIV_12M = 4;
    localparam int unsigned DIV_6M  = 8;

    // Channel indices in the default configuration
    localparam int unsigned CEN_12M  = 0;
    localparam int unsigned CEN_HCLK = 1;

    // Packs two 8-bit channel values; ch0 lands in the low slice.
    function automatic logic [15:0] pack_list2(input logic [7:0] ch1, input logic [7:0] ch0);
        return {ch1, ch0};
    endfunction

endpackage

// File: rtl/xsleena_cen_gen_if.sv
// -----------------------------------------------------------------------------
// xsleena_cen_gen_if
// Control and strobe bundle of the clock-enable generator.
//   i_pause    : freeze the pause-masked channels
//   i_resync   : one-cycle pulse, restart all counters aligned
//   o_cen      : per-channel strobe, one cycle wide
//   o_cen_h    : per-channel half-period companion strobe
//   o_frac_cen : fractional-N strobe, one cycle wide
// master drives the controls and observes the strobes; slave is the generator.
// -----------------------------------------------------------------------------
interface xsleena_cen_gen_if #(
    parameter int unsigned NUM_CH = 2
);
    logic              i_pause;
    logic              i_resync;
    logic [NUM_CH-1:0] o_cen;
    logic [NUM_CH-1:0] o_cen_h;
    logic              o_frac_cen;

    modport master (
        output i_pause,
        output i_resync,
        input  o_cen,
        input  o_cen_h,
        input  o_frac_cen
    );

    modport slave (
        input  i_pause,
        input  i_resync,
        output o_cen,
        output o_cen_h,
        output o_frac_cen
    );
endinterface

// File: rtl/xsleena_cen_div.sv
// -----------------------------------------------------------------------------
// xsleena_cen_div
// One integer clock-enable channel: a 0..DIV-1 wrap counter with registered
// phase and half-period compares.
//   i_clk   : core clock
//   i_rst   : synchronous reset, active-high
//   i_clr   : synchronous restart (resync), below i_rst in priority
//   i_hold  : freeze the counter and silence the strobes
//   o_cen   : high after the edge where the counter equals PHASE
//   o_cen_h : high after the edge where the counter equals PHASE + DIV/2 (mod DIV)
// -----------------------------------------------------------------------------
module xsleena_cen_div #(
    parameter int unsigned     CNT_W = 8,
    parameter logic [CNT_W-1:0] DIV   = 4,
    parameter logic [CNT_W-1:0] PHASE = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_hold,
    output logic o_cen,
    output logic o_cen_h
);

    localparam int unsigned DIV_INT  = int'(DIV);
    localparam int unsigned HALF_INT = (DIV_INT == 0) ? 0 :
                                       (int'(PHASE) + DIV_INT / 2) % DIV_INT;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_INT);
    localparam logic [CNT_W-1:0] LAST_CNT = DIV - 1'b1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_cen;
    logic             r_cen_h;

    logic [CNT_W-1:0] w_cnt_d;
    logic             w_cen_d;
    logic             w_cen_h_d;

    always_comb begin
        w_cnt_d   = r_cnt;
        w_cen_d   = 1'b0;
        w_cen_h_d = 1'b0;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (!i_hold) begin
            w_cen_d   = (r_cnt == PHASE);
            w_cen_h_d = (r_cnt == HALF_CNT);
            w_cnt_d   = (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_cen   <= 1'b0;
            r_cen_h <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_d;
            r_cen   <= w_cen_d;
            r_cen_h <= w_cen_h_d;
        end
    end

    assign o_cen   = r_cen;
    assign o_cen_h = r_cen_h;

endmodule

// File: rtl/xsleena_cen_gen.sv
// -----------------------------------------------------------------------------
// xsleena_cen_gen
// Clock-enable generator for the 48 MHz core domain: NUM_CH integer-divided
// strobes (each with a half-period companion) plus one fractional-N strobe.
//   i_clk  : 48 MHz core clock
//   i_rst  : synchronous reset, active-high
//   bus    : slave side of xsleena_cen_gen_if (pause/resync in, strobes out)
// Priority: i_rst > bus.i_resync > bus.i_pause. All outputs are registered.
// -----------------------------------------------------------------------------
module xsleena_cen_gen
    import xsleena_cen_pkg::*;
#(
    parameter int unsigned              NUM_CH        = 2,
    parameter int unsigned              CNT_W         = 8,
    parameter logic [NUM_CH*CNT_W-1:0]  DIV_LIST      = pack_list2(8'(DIV_6M), 8'(DIV_12M)),
    parameter logic [NUM_CH*CNT_W-1:0]  PHASE_LIST    = pack_list2(8'd1, 8'd0),
    parameter logic [NUM_CH-1:0]        PAUSE_MASK    = 2'b11,
    parameter int unsigned              FRAC_W        = 16,
    parameter int unsigned              FRAC_NUM      = 1,
    parameter int unsigned              FRAC_DEN      = 16,
    parameter bit                       FRAC_PAUSABLE = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    xsleena_cen_gen_if.slave  bus
);

    // ---------------------------------------------------------------- checks
    if (FRAC_DEN == 0) begin : g_err_den
        $error("xsleena_cen_gen: FRAC_DEN must be non-zero");
    end
    if (FRAC_NUM > FRAC_DEN) begin : g_err_num
        $error("xsleena_cen_gen: FRAC_NUM must not exceed FRAC_DEN");
    end

    // ------------------------------------------------------ integer channels
    logic [NUM_CH-1:0] w_cen;
    logic [NUM_CH-1:0] w_cen_h;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam logic [CNT_W-1:0] CH_DIV   = DIV_LIST[gi*CNT_W +: CNT_W];
        localparam logic [CNT_W-1:0] CH_PHASE = PHASE_LIST[gi*CNT_W +: CNT_W];

        if (CH_DIV == 0) begin : g_err_div
            $error("xsleena_cen_gen: channel %0d divisor is zero", gi);
        end
        if (CH_PHASE >= CH_DIV) begin : g_err_phase
            $error("xsleena_cen_gen: channel %0d phase not below divisor", gi);
        end

        xsleena_cen_div #(
            .CNT_W (CNT_W),
            .DIV   (CH_DIV),
            .PHASE (CH_PHASE)
        ) u_div (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_clr   (bus.i_resync),
            .i_hold  (bus.i_pause & PAUSE_MASK[gi]),
            .o_cen   (w_cen[gi]),
            .o_cen_h (w_cen_h[gi])
        );
    end

    assign bus.o_cen   = w_cen;
    assign bus.o_cen_h = w_cen_h;

    // ---------------------------------------------------- fractional channel
    // One extra bit on the sum so acc + NUM can never wrap.
    localparam logic [FRAC_W:0] NUM_EXT = (FRAC_W + 1)'(FRAC_NUM);
    localparam logic [FRAC_W:0] DEN_EXT = (FRAC_W + 1)'(FRAC_DEN);

    logic [FRAC_W-1:0] r_acc;
    logic              r_frac_cen;

    logic [FRAC_W:0]   w_sum;
    logic [FRAC_W:0]   w_diff;
    logic [FRAC_W-1:0] w_acc_d;
    logic              w_frac_cen_d;
    logic              w_frac_hold;

    assign w_sum       = {1'b0, r_acc} + NUM_EXT;
    assign w_diff      = w_sum - DEN_EXT;
    assign w_frac_hold = bus.i_pause & FRAC_PAUSABLE;

    always_comb begin
        w_acc_d      = r_acc;
        w_frac_cen_d = 1'b0;
        if (bus.i_resync) begin
            w_acc_d = '0;
        end else if (!w_frac_hold) begin
            if (w_sum >= DEN_EXT) begin
                w_acc_d      = w_diff[FRAC_W-1:0];
                w_frac_cen_d = 1'b1;
            end else begin
                w_acc_d = w_sum[FRAC_W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc      <= '0;
            r_frac_cen <= 1'b0;
        end else begin
            r_acc      <= w_acc_d;
            r_frac_cen <= w_frac_cen_d;
        end
    end

    assign bus.o_frac_cen = r_frac_cen;

endmodule

// File: tb/tb_xsleena_cen_gen.sv
// -----------------------------------------------------------------------------
// tb_xsleena_cen_gen
// Two generator instances sharing clock, reset and controls:
//   A: DIV {8,4}, PHASE {1,0}, PAUSE_MASK 01, frac 1/16
//   B: DIV {3,1}, PHASE {0,0}, PAUSE_MASK 11, frac 3/8
// Expected strobes come from a time-based model (active cycles since the last
// reset/resync) and are queued at drive time, then compared after the edge.
// -----------------------------------------------------------------------------
module tb_xsleena_cen_gen;
    import xsleena_cen_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pause = 1'b0;
    logic resync = 1'b0;

    always #5 clk = ~clk;

    xsleena_cen_gen_if #(.NUM_CH(2)) if_a ();
    xsleena_cen_gen_if #(.NUM_CH(2)) if_b ();

    assign if_a.i_pause  = pause;
    assign if_a.i_resync = resync;
    assign if_b.i_pause  = pause;
    assign if_b.i_resync = resync;

    xsleena_cen_gen #(
        .NUM_CH        (2),
        .CNT_W         (8),
        .DIV_LIST      (pack_list2(8'd8, 8'd4)),
        .PHASE_LIST    (pack_list2(8'd1, 8'd0)),
        .PAUSE_MASK    (2'b01),
        .FRAC_W        (16),
        .FRAC_NUM      (1),
        .FRAC_DEN      (16),
        .FRAC_PAUSABLE (1'b1)
    ) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_a.slave)
    );

    xsleena_cen_gen #(
        .NUM_CH        (2),
        .CNT_W         (8),
        .DIV_LIST      (pack_list2(8'd3, 8'd1)),
        .PHASE_LIST    (pack_list2(8'd0, 8'd0)),
        .PAUSE_MASK    (2'b11),
        .FRAC_W        (16),
        .FRAC_NUM      (3),
        .FRAC_DEN      (8),
        .FRAC_PAUSABLE (1'b1)
    ) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if_b.slave)
    );

    typedef struct packed {
        logic [1:0] cen_a;
        logic [1:0] ch_a;
        logic       fr_a;
        logic [1:0] cen_b;
        logic [1:0] ch_b;
        logic       fr_b;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Model configuration
    int div_a[2]  = '{4, 8};
    int ph_a[2]   = '{0, 1};
    bit mask_a[2] = '{1'b1, 1'b0};
    int div_b[2]  = '{1, 3};
    int ph_b[2]   = '{0, 0};
    bit mask_b[2] = '{1'b1, 1'b1};

    // Active (unpaused) cycles since the last reset/resync
    int n_a[2];
    int n_b[2];
    int m_a;
    int m_b;

    bit win = 1'b0;
    int frac_cnt = 0;
    int one_cnt = 0;

    function automatic logic exp_cen(input int n, input int d, input int p);
        return (n % d) == p;
    endfunction

    function automatic logic exp_half(input int n, input int d, input int p);
        return (n % d) == ((p + d / 2) % d);
    endfunction

    // A fractional pulse fires when floor(t*NUM/DEN) steps up.
    function automatic logic exp_frac(input int m, input int num, input int den);
        return ((m + 1) * num / den) != (m * num / den);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic p, input logic s);
        exp_t e;
        @(negedge clk);
        rst    = r;
        pause  = p;
        resync = s;
        e = '0;
        if (r || s) begin
            n_a = '{0, 0};
            n_b = '{0, 0};
            m_a = 0;
            m_b = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!(p && mask_a[i])) begin
                    e.cen_a[i] = exp_cen(n_a[i], div_a[i], ph_a[i]);
                    e.ch_a[i]  = exp_half(n_a[i], div_a[i], ph_a[i]);
                    n_a[i]++;
                end
                if (!(p && mask_b[i])) begin
                    e.cen_b[i] = exp_cen(n_b[i], div_b[i], ph_b[i]);
                    e.ch_b[i]  = exp_half(n_b[i], div_b[i], ph_b[i]);
                    n_b[i]++;
                end
            end
            if (!p) begin
                e.fr_a = exp_frac(m_a, 1, 16);
                e.fr_b = exp_frac(m_b, 3, 8);
                m_a++;
                m_b++;
            end
        end
        q.push_back(e);
    endtask

    // Scoreboard consumer: one expected entry per edge, checked just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cen_a",   32'(if_a.o_cen),      32'(e.cen_a));
            check("cen_h_a", 32'(if_a.o_cen_h),    32'(e.ch_a));
            check("frac_a",  32'(if_a.o_frac_cen), 32'(e.fr_a));
            check("cen_b",   32'(if_b.o_cen),      32'(e.cen_b));
            check("cen_h_b", 32'(if_b.o_cen_h),    32'(e.ch_b));
            check("frac_b",  32'(if_b.o_frac_cen), 32'(e.fr_b));
            if (win) begin
                if (if_b.o_frac_cen === 1'b1) frac_cnt++;
                if (if_b.o_cen[0] === 1'b1)   one_cnt++;
            end
        end
    end

    initial begin
        // Plain run from reset
        repeat (3) step(1'b1, 1'b0, 1'b0);
        repeat (24) step(1'b0, 1'b0, 1'b0);

        // Pause for t=10..12
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b0, 1'b0, 1'b0);

        // Resync at t=6
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (20) step(1'b0, 1'b0, 1'b0);

        // Reset mid-period together with pause and resync at t=5
        repeat (2) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (24) step(1'b0, 1'b0, 1'b0);

        // 800-cycle window on instance B: 3/8 rate and the DIV=1 channel
        repeat (2) step(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        win = 1'b1;
        repeat (800) step(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        win = 1'b0;

        check("frac_b_800_pulses", 32'(frac_cnt), 32'd300);
        check("cen_b0_const_one",  32'(one_cnt),  32'd800);
        check("queue_drained",     32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
